// File: rtl/lsu_param_if.sv
// Memory-side channel bundle between lsu_param and the per-thread memory controller port.
// master: driven by the LSU (valids, addresses, write data); slave: driven by memory (readys, read data).
//   mem_read_valid/address  -> memory     mem_read_ready/data  <- memory
//   mem_write_valid/address/data -> memory   mem_write_ready  <- memory
interface lsu_param_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu_param.sv
// Parametrised load/store unit for one compute thread.
// Decoded LDR/STR with base+offset addressing is turned into a single held
// valid/ready request on the memory channel; illegal decodes report lsu_error.
// Optional feature macro LSU_TIMEOUT_EN: abort a request after TIMEOUT_CYCLES
// enabled WAITING cycles without ready, reporting lsu_error.
// Ports:
//   clock, reset (async, active-low), enable (low freezes all state)
//   core_state      : core pipeline state (REQUEST=3'b011, UPDATE=3'b110)
//   mem_read_enable / mem_write_enable : decoded LDR / STR, sampled in IDLE only
//   rs_out, imm_offset, rt_out : base address, two's-complement offset, store data
//   mem             : memory channel (lsu_param_if.master)
//   lsu_out         : last loaded data
//   lsu_state       : IDLE=00, REQUESTING=01, WAITING=10, DONE=11
//   lsu_error       : current access failed (illegal decode or timeout)
module lsu_param #(
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 mem_read_enable,
    input  logic                 mem_write_enable,
    input  logic [ADDR_BITS-1:0] rs_out,
    input  logic [ADDR_BITS-1:0] imm_offset,
    input  logic [DATA_BITS-1:0] rt_out,
    lsu_param_if.master          mem,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic [1:0]           lsu_state,
    output logic                 lsu_error
);
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("lsu_param: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DONE       = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic                 is_write_q, is_write_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 err_q, err_d;
    logic [ADDR_BITS-1:0] eff_addr_c;
    logic                 ready_c;

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
`endif

    // Effective address wraps modulo 2^ADDR_BITS; negative offsets fall out of the same add.
    assign eff_addr_c = ADDR_BITS'(rs_out + imm_offset);
    // Only the channel of the outstanding request can complete it.
    assign ready_c    = is_write_q ? mem.mem_write_ready : mem.mem_read_ready;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        out_d      = out_q;
        err_d      = err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (core_state == CORE_REQUEST) begin
                    if (mem_read_enable && mem_write_enable) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (mem_read_enable || mem_write_enable) begin
                        is_write_d = mem_write_enable;
                        state_d    = REQUESTING;
                    end
                end
            end
            REQUESTING: begin
                if (is_write_q) begin
                    wr_addr_d  = eff_addr_c;
                    wr_data_d  = rt_out;
                    wr_valid_d = 1'b1;
                end else begin
                    rd_addr_d  = eff_addr_c;
                    rd_valid_d = 1'b1;
                end
`ifdef LSU_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = WAITING;
            end
            WAITING: begin
                if (ready_c) begin
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                    if (!is_write_q) begin
                        out_d = mem.mem_read_data;
                    end
                    state_d = DONE;
                end else begin
`ifdef LSU_TIMEOUT_EN
                    // Saturating count of ready-less cycles; reaching the limit aborts the request.
                    cnt_d = (cnt_q == TIMEOUT_LIM) ? cnt_q : cnt_q + 16'd1;
                    if (cnt_d == TIMEOUT_LIM) begin
                        rd_valid_d = 1'b0;
                        wr_valid_d = 1'b0;
                        err_d      = 1'b1;
                        state_d    = DONE;
                    end
`endif
                end
            end
            DONE: begin
                if (core_state == CORE_UPDATE) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset clears valids asynchronously so the bus sees the abort at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else if (enable) begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            out_q      <= out_d;
            err_q      <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign mem.mem_read_valid    = rd_valid_q;
    assign mem.mem_read_address  = rd_addr_q;
    assign mem.mem_write_valid   = wr_valid_q;
    assign mem.mem_write_address = wr_addr_q;
    assign mem.mem_write_data    = wr_data_q;
    assign lsu_out               = out_q;
    assign lsu_state             = state_q;
    assign lsu_error             = err_q;
endmodule

// File: tb/tb_lsu_param.sv
// Bench for lsu_param: a 12-bit-address and an 8-bit-address instance run in lockstep
// on the same core/memory stimulus and are checked against a transaction-level model.
module tb_lsu_param;
    localparam int unsigned T = 4;
`ifdef LSU_TIMEOUT_EN
    localparam bit HAS_TO = 1'b1;
`else
    localparam bit HAS_TO = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  core_state;
    logic        rd_en, wr_en;
    logic [11:0] rs, imm;
    logic [7:0]  rt;
    logic        rd_ready, wr_ready;
    logic [7:0]  rd_data;
    logic [7:0]  out12, out8;
    logic [1:0]  st12, st8;
    logic        err12, err8;

    int          n_pass = 0;
    int          n_checks = 0;
    logic [7:0]  exp_out = 8'h00;

    lsu_param_if #(.ADDR_BITS(12), .DATA_BITS(8)) bus12 ();
    lsu_param_if #(.ADDR_BITS(8),  .DATA_BITS(8)) bus8 ();

    assign bus12.mem_read_ready  = rd_ready;
    assign bus12.mem_read_data   = rd_data;
    assign bus12.mem_write_ready = wr_ready;
    assign bus8.mem_read_ready   = rd_ready;
    assign bus8.mem_read_data    = rd_data;
    assign bus8.mem_write_ready  = wr_ready;

    always #5 clock = ~clock;

    lsu_param #(.ADDR_BITS(12), .DATA_BITS(8), .TIMEOUT_CYCLES(T)) dut12 (
        .clock(clock), .reset(reset), .enable(enable), .core_state(core_state),
        .mem_read_enable(rd_en), .mem_write_enable(wr_en),
        .rs_out(rs), .imm_offset(imm), .rt_out(rt), .mem(bus12.master),
        .lsu_out(out12), .lsu_state(st12), .lsu_error(err12)
    );

    lsu_param #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(T)) dut8 (
        .clock(clock), .reset(reset), .enable(enable), .core_state(core_state),
        .mem_read_enable(rd_en), .mem_write_enable(wr_en),
        .rs_out(rs[7:0]), .imm_offset(imm[7:0]), .rt_out(rt), .mem(bus8.master),
        .lsu_out(out8), .lsu_state(st8), .lsu_error(err8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [11:0] ea12(input logic [11:0] a, input logic [11:0] b);
        return 12'((int'(a) + int'(b)) % 4096);
    endfunction

    function automatic logic [7:0] ea8(input logic [7:0] a, input logic [7:0] b);
        return 8'((int'(a) + int'(b)) % 256);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input int st, input bit rv, input bit wv, input bit err);
        check({tag, ".state12"}, 32'(st12), 32'(st));
        check({tag, ".state8"},  32'(st8),  32'(st));
        check({tag, ".rvalid12"}, 32'(bus12.mem_read_valid),  32'(rv));
        check({tag, ".rvalid8"},  32'(bus8.mem_read_valid),   32'(rv));
        check({tag, ".wvalid12"}, 32'(bus12.mem_write_valid), 32'(wv));
        check({tag, ".wvalid8"},  32'(bus8.mem_write_valid),  32'(wv));
        check({tag, ".err12"}, 32'(err12), 32'(err));
        check({tag, ".err8"},  32'(err8),  32'(err));
        check({tag, ".out12"}, 32'(out12), 32'(exp_out));
        check({tag, ".out8"},  32'(out8),  32'(exp_out));
    endtask

    task automatic check_req(input string tag, input bit is_wr, input logic [11:0] a12,
                             input logic [7:0] a8, input logic [7:0] d);
        if (is_wr) begin
            check({tag, ".waddr12"}, 32'(bus12.mem_write_address), 32'(a12));
            check({tag, ".waddr8"},  32'(bus8.mem_write_address),  32'(a8));
            check({tag, ".wdata12"}, 32'(bus12.mem_write_data), 32'(d));
            check({tag, ".wdata8"},  32'(bus8.mem_write_data),  32'(d));
        end else begin
            check({tag, ".raddr12"}, 32'(bus12.mem_read_address), 32'(a12));
            check({tag, ".raddr8"},  32'(bus8.mem_read_address),  32'(a8));
        end
    endtask

    // One core access: delay = WAITING cycles with ready low before ready; stall = disabled
    // cycles at the start of WAITING with ready high.
    task automatic run_txn(input bit rd, input bit wr, input logic [11:0] r, input logic [11:0] i,
                           input logic [7:0] d, input logic [7:0] md, input int delay, input int stall);
        logic [11:0] a12;
        logic [7:0]  a8;
        bit          done;
        bit          err_exp;
        a12 = ea12(r, i);
        a8  = ea8(r[7:0], i[7:0]);
        err_exp = 1'b0;
        rd_en = rd; wr_en = wr; rs = r; imm = i; rt = d; rd_data = md;
        rd_ready = 1'b0; wr_ready = 1'b0;
        core_state = 3'b011;
        step();
        core_state = 3'b000;
        rd_en = 1'($urandom); wr_en = 1'($urandom);
        if (rd && wr) begin
            err_exp = 1'b1;
            check_state("illegal", 3, 1'b0, 1'b0, 1'b1);
        end else if (!rd && !wr) begin
            check_state("noop", 0, 1'b0, 1'b0, 1'b0);
            return;
        end else begin
            check_state("req", 1, 1'b0, 1'b0, 1'b0);
            step();
            check_state("wait0", 2, rd, wr, 1'b0);
            check_req("wait0", wr, a12, a8, d);
            rs = 12'($urandom); imm = 12'($urandom); rt = 8'($urandom);
            if (stall > 0) begin
                enable = 1'b0;
                rd_ready = rd; wr_ready = wr;
                for (int s = 0; s < stall; s++) begin
                    step();
                    check_state("stall", 2, rd, wr, 1'b0);
                    check_req("stall", wr, a12, a8, d);
                end
                enable = 1'b1;
            end
            done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                rd_ready = rd ? (k == delay) : 1'($urandom);
                wr_ready = wr ? (k == delay) : 1'($urandom);
                rd_data  = (k == delay) ? md : 8'($urandom);
                step();
                if (k == delay) begin
                    done = 1'b1;
                    if (rd) exp_out = md;
                    check_state("complete", 3, 1'b0, 1'b0, 1'b0);
                end else if (HAS_TO && k + 1 == int'(T)) begin
                    done = 1'b1;
                    err_exp = 1'b1;
                    check_state("timeout", 3, 1'b0, 1'b0, 1'b1);
                end else begin
                    check_state("waiting", 2, rd, wr, 1'b0);
                    check_req("waiting", wr, a12, a8, d);
                end
            end
            if (!done) check("wait_bound", 32'd0, 32'd1);
            rd_ready = 1'b0; wr_ready = 1'b0;
        end
        repeat ($urandom_range(0, 2)) begin
            step();
            check_state("done_hold", 3, 1'b0, 1'b0, err_exp);
        end
        core_state = 3'b110;
        step();
        check_state("update", 0, 1'b0, 1'b0, 1'b0);
        core_state = 3'b000;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; core_state = 3'b000; rd_en = 1'b0; wr_en = 1'b0;
        rs = '0; imm = '0; rt = '0; rd_ready = 1'b0; wr_ready = 1'b0; rd_data = '0;
        repeat (2) step();
        check_state("reset", 0, 1'b0, 1'b0, 1'b0);
        check_req("reset_w", 1'b1, 12'h000, 8'h00, 8'h00);
        check_req("reset_r", 1'b0, 12'h000, 8'h00, 8'h00);
        reset = 1'b1;
        step();

        // Zero-wait load, wrapping store, negative offset, illegal decode.
        run_txn(1'b1, 1'b0, 12'h010, 12'h005, 8'h00, 8'hA5, 0, 0);
        run_txn(1'b0, 1'b1, 12'hFFE, 12'h003, 8'h3C, 8'h00, HAS_TO ? 3 : 4, 0);
        run_txn(1'b1, 1'b0, 12'h100, 12'hFFF, 8'h00, 8'h5A, 1, 0);
        run_txn(1'b1, 1'b1, 12'h123, 12'h456, 8'h77, 8'h00, 0, 0);
        // Long wait (aborts when the timeout is built in), then ready on the last allowed cycle.
        run_txn(1'b1, 1'b0, 12'h020, 12'h001, 8'h00, 8'hC3, 9, 0);
        run_txn(1'b1, 1'b0, 12'h030, 12'h002, 8'h00, 8'h96, 3, 0);
        run_txn(1'b0, 1'b1, 12'h040, 12'h003, 8'hE1, 8'h00, 9, 0);
        // Disabled for three cycles with ready high: nothing moves.
        run_txn(1'b1, 1'b0, 12'h050, 12'h004, 8'h00, 8'h69, 0, 3);

        // Asynchronous reset between edges while a load is outstanding.
        rd_en = 1'b1; wr_en = 1'b0; rs = 12'h060; imm = 12'h001; core_state = 3'b011;
        step();
        core_state = 3'b000;
        step();
        check("prereset.rvalid12", 32'(bus12.mem_read_valid), 32'd1);
        #3 reset = 1'b0;
        #1;
        exp_out = 8'h00;
        check_state("async_reset", 0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        step();
        check_state("post_reset", 0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int  op;
            int  dly;
            op  = int'($urandom_range(0, 9));
            dly = HAS_TO ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 5));
            run_txn((op == 0) || (op >= 2 && op % 2 == 0), (op == 0) || (op >= 2 && op % 2 == 1),
                    12'($urandom), 12'($urandom), 8'($urandom), 8'($urandom),
                    dly, (op == 9) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu_param.md
# lsu_param

Parametrised load/store unit for one compute thread, the successor to the fixed 8-bit LSU. It sits between a core's register file/decoder and the memory controller's per-thread channel. Adds width parameters, base-plus-offset addressing, a held valid/ready request handshake, illegal-decode detection and an optional response timeout with error reporting.

## Interface
- ADDR_BITS, 8, address width; also the offset width
- DATA_BITS, 8, data width
- TIMEOUT_CYCLES, 255, WAITING cycles without `ready` before abort (requires LSU_TIMEOUT_EN); must be ≥1 and < 2^16
- `clock` in 1: single clock; all logic on its rising edge
- `reset` in 1: asynchronous, active-low
- `enable` in 1: thread active; low freezes all registers
- `core_state` in 3: core pipeline state; 3'b011 = REQUEST, 3'b110 = UPDATE
- `mem_read_enable` in 1: decoded LDR
- `mem_write_enable` in 1: decoded STR
- `rs_out` in ADDR_BITS: base address
- `imm_offset` in ADDR_BITS: two's-complement offset
- `rt_out` in DATA_BITS: store data
- `mem_read_valid` out 1 / `mem_read_address` out ADDR_BITS / `mem_read_ready` in 1 / `mem_read_data` in DATA_BITS
- `mem_write_valid` out 1 / `mem_write_address` out ADDR_BITS / `mem_write_data` out DATA_BITS / `mem_write_ready` in 1
- `lsu_out` out DATA_BITS: last loaded data
- `lsu_state` out 2: IDLE=00, REQUESTING=01, WAITING=10, DONE=11
- `lsu_error` out 1: current access failed (illegal decode or timeout)

## Operation
- Reset (`reset`=0): `lsu_state`=IDLE. All other outputs 0. Timeout counter 0.
- `enable`=0: state, counter and all outputs hold. `ready` is ignored.
- IDLE: on `core_state`==REQUEST:
  - exactly one of read/write enable set -> REQUESTING
  - both set -> DONE with `lsu_error`=1; no bus activity
  - neither set -> stay in IDLE
- REQUESTING, one cycle:
  - effective address = (`rs_out` + `imm_offset`) mod 2^ADDR_BITS; the carry is discarded.
  - Register it into the read or write address.
  - Store: register `rt_out` into `mem_write_data`.
  - Set the matching valid to 1. Clear the counter. -> WAITING
- WAITING: valid, address and data are held stable until the matching `ready` is sampled 1.
  - On `ready`: valid <= 0. Load: `lsu_out` <= `mem_read_data`. -> DONE.
  - The opposite channel's `ready` is ignored.
- DONE: hold until `core_state`==UPDATE.
  - Then -> IDLE and `lsu_error` <= 0.
  - `lsu_out` keeps its value.
- Read/write enables are sampled only in IDLE; changes in later states are ignored.

## Timing
- Zero-wait load, counting rising edges from the edge that samples REQUEST in IDLE:
  - edge 1 -> REQUESTING
  - edge 2 -> WAITING, `mem_read_valid`=1
  - edge 3 samples `ready`=1 -> DONE, `lsu_out` valid
- Each cycle `ready` stays low adds one cycle.
- Valid is a registered output and never combinationally depends on `ready`.
- Valid deasserts on the edge that samples `ready`=1. There is at most one outstanding request.
- `reset` asserted mid-access: valid drops immediately (asynchronous). The memory side must drop the transaction.
- The counter saturates at TIMEOUT_CYCLES and never wraps.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A 16-bit counter increments each enabled WAITING cycle with `ready`=0.
  - When it equals TIMEOUT_CYCLES and `ready`=0: valid <= 0, `lsu_error` <= 1, `lsu_out` unchanged, -> DONE.
  - `ready`=1 on the same cycle wins: normal completion, no error.
- Not defined: no counter. WAITING waits indefinitely. `lsu_error` is set only by illegal decode.

## Test plan
- Load, ADDR/DATA=8: `rs_out`=0x10, `imm_offset`=0x05, `mem_read_data`=0xA5, `ready` on first WAITING cycle -> `mem_read_address`=0x15, DONE 3 edges after the REQUEST sample, `lsu_out`=0xA5, `lsu_error`=0; UPDATE -> IDLE.
- Store with 4 wait cycles: `rs_out`=0xFE, `imm_offset`=0x03, `rt_out`=0x3C:
  - `mem_write_address`=0x01 (wrap); data 0x3C held stable with valid for 5 cycles
  - valid low after `ready`; `lsu_out` unchanged
- Negative offset, ADDR_BITS=12: `rs_out`=0x100, `imm_offset`=0xFFF -> address 0x0FF.
- Both enables set at REQUEST -> DONE next edge, `lsu_error`=1, both valids remain 0; error clears on UPDATE.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, `ready` never asserted:
  - valid drops after 4 WAITING cycles; DONE with `lsu_error`=1, `lsu_out` unchanged
  - repeat with `ready` on the 4th cycle -> normal completion, no error
- `reset` pulsed low mid-WAITING, between clock edges -> valid and `lsu_state` are 0 immediately; `enable`=0 for 3 cycles in WAITING with `ready`=1 -> state holds, no capture.
